// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues indirect-jump mispredicts until they commit,
// then writes the corrected target into the BTB one cycle after commit.
module btb_update_ctrl #(
    parameter int unsigned VLEN          = 64,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic                       resolve_valid_i,
    input  logic                       resolve_is_jalr_i,
    input  logic [VLEN-1:0]            resolve_pc_i,
    input  logic [VLEN-1:0]            resolve_target_i,
    input  logic                       resolve_pred_valid_i,
    input  logic [VLEN-1:0]            resolve_pred_target_i,
    input  logic [TRANS_ID_BITS-1:0]   resolve_trans_id_i,
    input  logic                       commit_valid_i,
    input  logic [TRANS_ID_BITS-1:0]   commit_trans_id_i,
    output logic                       btb_update_valid_o,
    output logic [VLEN-1:0]            btb_update_pc_o,
    output logic [VLEN-1:0]            btb_update_target_o,
    output logic                       mispredict_o,
    output logic                       drop_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [VLEN-1:0]          q_pc  [DEPTH];
    logic [VLEN-1:0]          q_tgt [DEPTH];
    logic [TRANS_ID_BITS-1:0] q_id  [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic mispredict;
    logic qualified;
    logic pop;
    logic space;
    logic push;
    logic drop;

    // Classify the resolved branch and decide queue push/pop this cycle
    always_comb begin
        mispredict = resolve_valid_i & resolve_is_jalr_i &
                     (~resolve_pred_valid_i |
                      (resolve_pred_target_i != resolve_target_i));
        qualified  = mispredict & ~debug_mode_i & ~flush_i;
        pop        = commit_valid_i & (count_q != '0) &
                     (q_id[head_q] == commit_trans_id_i) & ~flush_i;
        space      = (count_q < FULL) | pop;
        push       = qualified & space;
        drop       = qualified & ~space;
    end

    // Queue storage: write the new entry at the tail on push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc[i]  <= '0;
                q_tgt[i] <= '0;
                q_id[i]  <= '0;
            end
        end else if (push) begin
            q_pc[tail_q]  <= resolve_pc_i;
            q_tgt[tail_q] <= resolve_target_i;
            q_id[tail_q]  <= resolve_trans_id_i;
        end
    end

    // Pointers and occupancy; flush empties the queue outright
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered BTB write and status pulses; pc/target hold when idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btb_update_valid_o  <= 1'b0;
            btb_update_pc_o     <= '0;
            btb_update_target_o <= '0;
            mispredict_o        <= 1'b0;
            drop_o              <= 1'b0;
        end else begin
            btb_update_valid_o <= pop;
            mispredict_o       <= qualified;
            drop_o             <= drop;
            if (pop) begin
                btb_update_pc_o     <= q_pc[head_q];
                btb_update_target_o <= q_tgt[head_q];
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl (default parameters).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_btb_update_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        debug_mode_i;
    logic        resolve_valid_i;
    logic        resolve_is_jalr_i;
    logic [63:0] resolve_pc_i;
    logic [63:0] resolve_target_i;
    logic        resolve_pred_valid_i;
    logic [63:0] resolve_pred_target_i;
    logic [2:0]  resolve_trans_id_i;
    logic        commit_valid_i;
    logic [2:0]  commit_trans_id_i;
    logic        btb_update_valid_o;
    logic [63:0] btb_update_pc_o;
    logic [63:0] btb_update_target_o;
    logic        mispredict_o;
    logic        drop_o;
    logic [2:0]  count_o;

    int vecs = 0;
    int errs = 0;

    btb_update_ctrl dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .debug_mode_i          (debug_mode_i),
        .resolve_valid_i       (resolve_valid_i),
        .resolve_is_jalr_i     (resolve_is_jalr_i),
        .resolve_pc_i          (resolve_pc_i),
        .resolve_target_i      (resolve_target_i),
        .resolve_pred_valid_i  (resolve_pred_valid_i),
        .resolve_pred_target_i (resolve_pred_target_i),
        .resolve_trans_id_i    (resolve_trans_id_i),
        .commit_valid_i        (commit_valid_i),
        .commit_trans_id_i     (commit_trans_id_i),
        .btb_update_valid_o    (btb_update_valid_o),
        .btb_update_pc_o       (btb_update_pc_o),
        .btb_update_target_o   (btb_update_target_o),
        .mispredict_o          (mispredict_o),
        .drop_o                (drop_o),
        .count_o               (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic set_res(input logic [63:0] pc, input logic [63:0] tgt,
                           input logic pv, input logic [63:0] pt,
                           input logic [2:0] id);
        resolve_valid_i       = 1'b1;
        resolve_is_jalr_i     = 1'b1;
        resolve_pc_i          = pc;
        resolve_target_i      = tgt;
        resolve_pred_valid_i  = pv;
        resolve_pred_target_i = pt;
        resolve_trans_id_i    = id;
    endtask

    task automatic set_com(input logic [2:0] id);
        commit_valid_i    = 1'b1;
        commit_trans_id_i = id;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        resolve_valid_i = 1'b0;
        commit_valid_i  = 1'b0;
        flush_i         = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vecs++; if (count_o !== 3'd0) begin $display("FAIL rst_count got %0d want 0", count_o); errs++; end
        vecs++; if (btb_update_valid_o !== 1'b0) begin $display("FAIL rst_valid got %b want 0", btb_update_valid_o); errs++; end
        vecs++; if (btb_update_pc_o !== 64'd0 || btb_update_target_o !== 64'd0) begin $display("FAIL rst_pc_tgt got %h/%h want 0/0", btb_update_pc_o, btb_update_target_o); errs++; end
        vecs++; if (mispredict_o !== 1'b0 || drop_o !== 1'b0) begin $display("FAIL rst_pulses got %b%b want 00", mispredict_o, drop_o); errs++; end
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        set_res(64'h1000, 64'h2000, 1'b0, 64'h0, 3'd2);
        tick();
        vecs++; if (mispredict_o !== 1'b1) begin $display("FAIL basic_mis got %b want 1", mispredict_o); errs++; end
        vecs++; if (count_o !== 3'd1) begin $display("FAIL basic_count1 got %0d want 1", count_o); errs++; end
        vecs++; if (btb_update_valid_o !== 1'b0) begin $display("FAIL basic_novalid got %b want 0", btb_update_valid_o); errs++; end
        set_com(3'd2);
        tick();
        vecs++; if (btb_update_valid_o !== 1'b1) begin $display("FAIL basic_valid got %b want 1", btb_update_valid_o); errs++; end
        vecs++; if (btb_update_pc_o !== 64'h1000) begin $display("FAIL basic_pc got %h want 1000", btb_update_pc_o); errs++; end
        vecs++; if (btb_update_target_o !== 64'h2000) begin $display("FAIL basic_tgt got %h want 2000", btb_update_target_o); errs++; end
        vecs++; if (count_o !== 3'd0) begin $display("FAIL basic_count0 got %0d want 0", count_o); errs++; end
        vecs++; if (mispredict_o !== 1'b0) begin $display("FAIL basic_mis_clr got %b want 0", mispredict_o); errs++; end
        tick();
        vecs++; if (btb_update_valid_o !== 1'b0) begin $display("FAIL basic_pulse got %b want 0", btb_update_valid_o); errs++; end
        vecs++; if (btb_update_pc_o !== 64'h1000) begin $display("FAIL basic_hold got %h want 1000", btb_update_pc_o); errs++; end
    endtask

    task automatic test_predict();
        set_res(64'h1100, 64'h3000, 1'b1, 64'h3000, 3'd1);
        tick();
        vecs++; if (mispredict_o !== 1'b0 || count_o !== 3'd0) begin $display("FAIL pred_ok got mis=%b cnt=%0d want 0/0", mispredict_o, count_o); errs++; end
        set_res(64'h1104, 64'h3000, 1'b0, 64'h0, 3'd1);
        resolve_is_jalr_i = 1'b0;
        tick();
        vecs++; if (mispredict_o !== 1'b0 || count_o !== 3'd0) begin $display("FAIL pred_nonjalr got mis=%b cnt=%0d want 0/0", mispredict_o, count_o); errs++; end
        set_res(64'h1108, 64'h3000, 1'b1, 64'h8000_0000_0000_3000, 3'd5);
        tick();
        vecs++; if (mispredict_o !== 1'b1 || count_o !== 3'd1) begin $display("FAIL pred_msb got mis=%b cnt=%0d want 1/1", mispredict_o, count_o); errs++; end
        set_com(3'd5);
        tick();
        vecs++; if (btb_update_valid_o !== 1'b1 || btb_update_pc_o !== 64'h1108) begin $display("FAIL pred_msb_upd got v=%b pc=%h want 1/1108", btb_update_valid_o, btb_update_pc_o); errs++; end
        tick();
    endtask

    task automatic fill4(input logic [2:0] base);
        for (int i = 0; i < 4; i++) begin
            set_res(64'h1000 + 64'(i * 4), 64'h4000 + 64'(i * 4),
                    1'b0, 64'h0, base + 3'(i));
            tick();
            vecs++; if (count_o !== 3'(i + 1)) begin $display("FAIL fill_count%0d got %0d want %0d", i, count_o, i + 1); errs++; end
        end
    endtask

    task automatic test_full_drop();
        fill4(3'd0);
        set_res(64'h1010, 64'h4010, 1'b0, 64'h0, 3'd4);
        tick();
        vecs++; if (drop_o !== 1'b1 || mispredict_o !== 1'b1) begin $display("FAIL full_drop got drop=%b mis=%b want 1/1", drop_o, mispredict_o); errs++; end
        vecs++; if (count_o !== 3'd4) begin $display("FAIL full_count got %0d want 4", count_o); errs++; end
        set_com(3'd3);
        tick();
        vecs++; if (btb_update_valid_o !== 1'b0 || count_o !== 3'd4 || drop_o !== 1'b0) begin $display("FAIL full_nohead got v=%b cnt=%0d drop=%b want 0/4/0", btb_update_valid_o, count_o, drop_o); errs++; end
        for (int i = 0; i < 4; i++) begin
            set_com(3'(i));
            tick();
            vecs++; if (btb_update_valid_o !== 1'b1 || btb_update_pc_o !== 64'h1000 + 64'(i * 4) || btb_update_target_o !== 64'h4000 + 64'(i * 4)) begin
                $display("FAIL drain%0d got v=%b pc=%h tgt=%h want 1/%h/%h", i, btb_update_valid_o, btb_update_pc_o, btb_update_target_o, 64'h1000 + 64'(i * 4), 64'h4000 + 64'(i * 4)); errs++; end
            vecs++; if (count_o !== 3'(3 - i)) begin $display("FAIL drain_count%0d got %0d want %0d", i, count_o, 3 - i); errs++; end
        end
        set_com(3'd4);
        tick();
        vecs++; if (btb_update_valid_o !== 1'b0 || count_o !== 3'd0) begin $display("FAIL dropped_id got v=%b cnt=%0d want 0/0", btb_update_valid_o, count_o); errs++; end
    endtask

    task automatic test_back_to_back();
        fill4(3'd0);
        set_res(64'h1010, 64'h4010, 1'b0, 64'h0, 3'd4);
        set_com(3'd0);
        tick();
        vecs++; if (drop_o !== 1'b0 || count_o !== 3'd4) begin $display("FAIL b2b_accept got drop=%b cnt=%0d want 0/4", drop_o, count_o); errs++; end
        vecs++; if (btb_update_valid_o !== 1'b1 || btb_update_pc_o !== 64'h1000) begin $display("FAIL b2b_pop0 got v=%b pc=%h want 1/1000", btb_update_valid_o, btb_update_pc_o); errs++; end
        for (int i = 1; i < 5; i++) begin
            set_com(3'(i));
            tick();
            vecs++; if (btb_update_valid_o !== 1'b1 || btb_update_pc_o !== 64'h1000 + 64'(i * 4)) begin
                $display("FAIL b2b_drain%0d got v=%b pc=%h want 1/%h", i, btb_update_valid_o, btb_update_pc_o, 64'h1000 + 64'(i * 4)); errs++; end
        end
        vecs++; if (count_o !== 3'd0) begin $display("FAIL b2b_empty got %0d want 0", count_o); errs++; end
        set_com(3'd0);
        tick();
        vecs++; if (count_o !== 3'd0 || btb_update_valid_o !== 1'b0) begin $display("FAIL underflow got cnt=%0d v=%b want 0/0", count_o, btb_update_valid_o); errs++; end
    endtask

    task automatic test_flush_debug();
        set_res(64'h2000, 64'h5000, 1'b0, 64'h0, 3'd6);
        tick();
        set_res(64'h2004, 64'h5004, 1'b0, 64'h0, 3'd7);
        tick();
        vecs++; if (count_o !== 3'd2) begin $display("FAIL flush_pre got %0d want 2", count_o); errs++; end
        set_res(64'h2008, 64'h5008, 1'b0, 64'h0, 3'd0);
        set_com(3'd6);
        flush_i = 1'b1;
        tick();
        vecs++; if (btb_update_valid_o !== 1'b0 || count_o !== 3'd0) begin $display("FAIL flush got v=%b cnt=%0d want 0/0", btb_update_valid_o, count_o); errs++; end
        vecs++; if (mispredict_o !== 1'b0 || drop_o !== 1'b0) begin $display("FAIL flush_pulses got %b%b want 00", mispredict_o, drop_o); errs++; end
        set_com(3'd6);
        tick();
        vecs++; if (btb_update_valid_o !== 1'b0) begin $display("FAIL flush_gone got %b want 0", btb_update_valid_o); errs++; end
        debug_mode_i = 1'b1;
        set_res(64'h2100, 64'h5100, 1'b0, 64'h0, 3'd1);
        tick();
        vecs++; if (mispredict_o !== 1'b0 || count_o !== 3'd0) begin $display("FAIL debug_block got mis=%b cnt=%0d want 0/0", mispredict_o, count_o); errs++; end
        debug_mode_i = 1'b0;
        set_res(64'h2200, 64'h5200, 1'b0, 64'h0, 3'd3);
        set_com(3'd3);
        tick();
        vecs++; if (count_o !== 3'd1 || btb_update_valid_o !== 1'b0) begin $display("FAIL samecyc got cnt=%0d v=%b want 1/0", count_o, btb_update_valid_o); errs++; end
        debug_mode_i = 1'b1;
        set_com(3'd3);
        tick();
        vecs++; if (btb_update_valid_o !== 1'b1 || btb_update_pc_o !== 64'h2200 || count_o !== 3'd0) begin $display("FAIL debug_pop got v=%b pc=%h cnt=%0d want 1/2200/0", btb_update_valid_o, btb_update_pc_o, count_o); errs++; end
        debug_mode_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        fill4(3'd0);
        set_com(3'd0);
        tick();
        vecs++; if (btb_update_valid_o !== 1'b1 || count_o !== 3'd3) begin $display("FAIL mid_pre got v=%b cnt=%0d want 1/3", btb_update_valid_o, count_o); errs++; end
        set_com(3'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        vecs++; if (btb_update_valid_o !== 1'b0 || count_o !== 3'd0) begin $display("FAIL mid_rst got v=%b cnt=%0d want 0/0", btb_update_valid_o, count_o); errs++; end
        vecs++; if (btb_update_pc_o !== 64'd0 || btb_update_target_o !== 64'd0 || mispredict_o !== 1'b0 || drop_o !== 1'b0) begin
            $display("FAIL mid_rst_out got pc=%h tgt=%h mis=%b drop=%b want 0", btb_update_pc_o, btb_update_target_o, mispredict_o, drop_o); errs++; end
        tick();
        set_com(3'd1);
        rst_ni = 1'b1;
        tick();
        vecs++; if (btb_update_valid_o !== 1'b0 || count_o !== 3'd0) begin $display("FAIL post_rst got v=%b cnt=%0d want 0/0", btb_update_valid_o, count_o); errs++; end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        set_res(64'h3000, 64'h6000, 1'b0, 64'h0, 3'd2);
        tick();
        vecs++; if (count_o !== 3'd1 || mispredict_o !== 1'b1) begin $display("FAIL first_push got cnt=%0d mis=%b want 1/1", count_o, mispredict_o); errs++; end
        set_com(3'd2);
        tick();
        vecs++; if (btb_update_valid_o !== 1'b1 || btb_update_target_o !== 64'h6000) begin $display("FAIL first_pop got v=%b tgt=%h want 1/6000", btb_update_valid_o, btb_update_target_o); errs++; end
    endtask

    initial begin
        rst_ni                = 1'b0;
        flush_i               = 1'b0;
        debug_mode_i          = 1'b0;
        resolve_valid_i       = 1'b0;
        resolve_is_jalr_i     = 1'b0;
        resolve_pc_i          = '0;
        resolve_target_i      = '0;
        resolve_pred_valid_i  = 1'b0;
        resolve_pred_target_i = '0;
        resolve_trans_id_i    = '0;
        commit_valid_i        = 1'b0;
        commit_trans_id_i     = '0;
        test_reset();
        test_basic();
        test_predict();
        test_full_drop();
        test_back_to_back();
        test_flush_debug();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 Parameter VLEN, default 64: virtual address width.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2): pending-update queue entries.
REQ-003 Parameter TRANS_ID_BITS, default 3: scoreboard transaction id width.
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  pipeline squash; discard all uncommitted pending updates.
REQ-007 debug_mode_i  in  1  core in debug mode; no new updates captured.
REQ-008 resolve_valid_i  in  1  execute resolved a control-flow instruction this cycle.
REQ-009 resolve_is_jalr_i  in  1  resolved instruction is an indirect jump.
REQ-010 resolve_pc_i / resolve_target_i  in  VLEN each  instruction PC / resolved target.
REQ-011 resolve_pred_valid_i / resolve_pred_target_i  in  1 / VLEN  frontend BTB prediction used.
REQ-012 resolve_trans_id_i  in  TRANS_ID_BITS  scoreboard id of resolved instruction.
REQ-013 commit_valid_i / commit_trans_id_i  in  1 / TRANS_ID_BITS  instruction committed this cycle.
REQ-014 btb_update_valid_o  out  1  write request to BTB (one-cycle pulse, BTB always accepts).
REQ-015 btb_update_pc_o / btb_update_target_o  out  VLEN each  BTB write PC / target.
REQ-016 mispredict_o  out  1  registered pulse: qualifying indirect mispredict detected.
REQ-017 drop_o  out  1  registered pulse: mispredict lost because queue full.
REQ-018 count_o  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 Mispredict = resolve_valid_i & resolve_is_jalr_i & (!resolve_pred_valid_i | resolve_pred_target_i != resolve_target_i), full VLEN compare.
REQ-020 Push = mispredict & !debug_mode_i & !flush_i & space; space = count<DEPTH or a pop occurs same cycle.
REQ-021 Pushed entry stores {pc, target, trans_id}; queue is in-order FIFO, wrap-around pointers modulo DEPTH.
REQ-022 Pop = commit_valid_i & count>0 & head.trans_id == commit_trans_id_i & !flush_i.
REQ-023 Commit whose id mismatches head, or with empty queue: no state change.
REQ-024 On pop, next cycle btb_update_valid_o=1 with head pc/target; otherwise btb_update_valid_o=0 next cycle; pc/target outputs hold last value when not valid.
REQ-025 Latency commit -> BTB write = exactly 1 cycle; at most one update per cycle.
REQ-026 mispredict_o=1 next cycle for every mispredict with !debug_mode_i & !flush_i, regardless of queue space.
REQ-027 Queue full and no pop: mispredict not stored, drop_o=1 next cycle, existing entries unchanged.
REQ-028 Full with simultaneous pop: push accepted, count unchanged, drop_o=0.
REQ-029 Empty with simultaneous push and matching commit of the same id: no pop that cycle (entry not yet present); pop on a later matching commit only.
REQ-030 flush_i has priority: next cycle count=0, pointers reset, btb_update_valid_o=0, mispredict_o=0, drop_o=0; same-cycle push/pop ignored.
REQ-031 debug_mode_i blocks pushes only; already queued entries still pop on commit.
REQ-032 count_o updates cycle after push/pop; never exceeds DEPTH, never underflows.

Reset
REQ-033 rst_ni low asynchronously clears queue, pointers, count_o=0, btb_update_valid_o=0, btb_update_pc_o=0, btb_update_target_o=0, mispredict_o=0, drop_o=0, at any point incl. mid-drain.
REQ-034 First push accepted on first rising edge after rst_ni deasserts.

Verification
REQ-035 Resolve jalr pc=0x1000 target=0x2000 pred_valid=0 id=2, then commit id=2 -> mispredict_o pulse, count 1, then btb_update_valid_o=1 pc=0x1000 target=0x2000 one cycle after commit, count 0.
REQ-036 Resolve jalr pred_valid=1 pred_target=target=0x3000 -> no push, mispredict_o=0, count stays 0.
REQ-037 Push 4 mispredicts ids 0..3 then a fifth (id 4) -> drop_o pulse, count 4; commits 0,1,2,3 -> four consecutive updates in order; commit id 4 -> no update.
REQ-038 Full queue, fifth mispredict same cycle as commit id 0 -> accepted, drop_o=0, count 4, later drains ids 1..4.
REQ-039 Two queued entries, flush_i with matching commit same cycle -> no update, count 0; debug_mode_i=1 mispredict -> no push, mispredict_o=0.
REQ-040 rst_ni asserted with 3 entries queued and commit pending -> all outputs 0 immediately, no update after release.
